// File: rtl/memctrl_remap.sv
// Memory front end: arbitrates the banked main SRAM between BIST and functional
// access, and steers functional hits on a BIST-filled repair table to a spare SRAM.
module memctrl_remap #(
  parameter int BANK_AW = 6,
  parameter int WORD_AW = 10,
  parameter int DW      = 8,
  parameter int SPARE_N = 16,
  localparam int NBANK    = 2**BANK_AW,
  localparam int SPARE_AW = $clog2(SPARE_N),
  localparam int AW       = BANK_AW + WORD_AW
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                BIST_EN,
  input  logic                REPAIR_EN,
  input  logic                REPAIR_CLR,
  input  logic                CSB,
  input  logic                WEB,
  input  logic                OEB,
  input  logic [AW-1:0]       ADDR,
  input  logic [DW-1:0]       IDATA,
  input  logic [WORD_AW-1:0]  BIST_MEM_ADDR,
  input  logic                BIST_MEM_CE,
  input  logic                BIST_MEM_WEB,
  input  logic [NBANK-1:0]    BIST_MEM_CSB,
  input  logic [NBANK-1:0]    BIST_MEM_OEB,
  input  logic [DW-1:0]       BIST_MEM_IDATA,
  input  logic [BANK_AW-1:0]  BIST_MEM_ODATA_SELECT,
  input  logic                FAIL_VALID,
  input  logic [AW-1:0]       FAIL_ADDR,
  input  logic [DW-1:0]       MEM_ODATA,
  input  logic [DW-1:0]       SPARE_ODATA,
  output logic [WORD_AW-1:0]  MEM_ADDR,
  output logic                MEM_CE,
  output logic                MEM_WEB,
  output logic [NBANK-1:0]    MEM_CSB,
  output logic [NBANK-1:0]    MEM_OEB,
  output logic [DW-1:0]       MEM_IDATA,
  output logic [BANK_AW-1:0]  MEM_ODATA_SELECT,
  output logic [SPARE_AW-1:0] SPARE_ADDR,
  output logic                SPARE_CE,
  output logic                SPARE_CSB,
  output logic                SPARE_WEB,
  output logic                SPARE_OEB,
  output logic [DW-1:0]       SPARE_IDATA,
  output logic [DW-1:0]       ODATA,
  output logic                RVALID,
  output logic [SPARE_AW:0]   REPAIR_CNT,
  output logic                REPAIR_FULL,
  output logic                REPAIR_OVF
);

  localparam logic [NBANK-1:0]  BANK_ONE = {{(NBANK-1){1'b0}}, 1'b1};
  localparam logic [SPARE_AW:0] CNT_ONE  = {{SPARE_AW{1'b0}}, 1'b1};
  localparam logic [SPARE_AW:0] CNT_MAX  = (SPARE_AW+1)'(SPARE_N);

  logic [SPARE_N-1:0]  tbl_valid_r;
  logic [AW-1:0]       tbl_addr_r [SPARE_N];
  logic [SPARE_AW:0]   repair_cnt_r;
  logic                repair_full_r, repair_ovf_r;
  logic                fail_match_s, hit_s, insert_s, rd_req_s;
  logic [SPARE_AW-1:0] hit_idx_s;
  logic [BANK_AW-1:0]  bank_s;
  logic [WORD_AW-1:0]  word_s;

  logic [WORD_AW-1:0]  mem_addr_s, mem_addr_r;
  logic                mem_ce_s, mem_ce_r, mem_web_s, mem_web_r;
  logic [NBANK-1:0]    mem_csb_s, mem_csb_r, mem_oeb_s, mem_oeb_r;
  logic [DW-1:0]       mem_idata_s, mem_idata_r;
  logic [BANK_AW-1:0]  mem_sel_s, mem_sel_r;
  logic [SPARE_AW-1:0] spare_addr_s, spare_addr_r;
  logic                spare_ce_s, spare_ce_r, spare_csb_s, spare_csb_r;
  logic                spare_web_s, spare_web_r, spare_oeb_s, spare_oeb_r;
  logic [DW-1:0]       spare_idata_s, spare_idata_r;
  logic                p1_vld_r, p1_hit_r, p2_vld_r, p2_hit_r;

  assign bank_s   = ADDR[AW-1:WORD_AW];
  assign word_s   = ADDR[WORD_AW-1:0];
  assign insert_s = BIST_EN && FAIL_VALID && !fail_match_s;
  assign rd_req_s = !BIST_EN && !CSB && WEB && !OEB;

  // Parallel compare of functional and failing addresses against valid entries
  always_comb begin
    fail_match_s = 1'b0;
    hit_s        = 1'b0;
    hit_idx_s    = {SPARE_AW{1'b0}};
    for (int i = 0; i < SPARE_N; i++) begin
      fail_match_s = fail_match_s | (tbl_valid_r[i] && (tbl_addr_r[i] == FAIL_ADDR));
      if (!hit_s && tbl_valid_r[i] && (tbl_addr_r[i] == ADDR)) begin
        hit_s     = 1'b1;
        hit_idx_s = SPARE_AW'(i);
      end else begin
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Repair table fill, clear and overflow tracking; clear wins over insert
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tbl_valid_r   <= {SPARE_N{1'b0}};
      repair_cnt_r  <= {(SPARE_AW+1){1'b0}};
      repair_full_r <= 1'b0;
      repair_ovf_r  <= 1'b0;
      for (int i = 0; i < SPARE_N; i++) tbl_addr_r[i] <= {AW{1'b0}};
    end else if (REPAIR_CLR) begin
      tbl_valid_r   <= {SPARE_N{1'b0}};
      repair_cnt_r  <= {(SPARE_AW+1){1'b0}};
      repair_full_r <= 1'b0;
      repair_ovf_r  <= 1'b0;
    end else if (insert_s) begin
      if (repair_cnt_r < CNT_MAX) begin
        tbl_valid_r[repair_cnt_r[SPARE_AW-1:0]] <= 1'b1;
        tbl_addr_r[repair_cnt_r[SPARE_AW-1:0]]  <= FAIL_ADDR;
        repair_cnt_r  <= repair_cnt_r + CNT_ONE;
        repair_full_r <= ((repair_cnt_r + CNT_ONE) == CNT_MAX);
      end else begin
        repair_ovf_r <= 1'b1;
      end
    end else begin
      repair_ovf_r <= repair_ovf_r;
    end
  end

  // Route the sampled request to main or spare; anything unused stays idle
  always_comb begin
    mem_addr_s    = {WORD_AW{1'b0}};
    mem_ce_s      = 1'b0;
    mem_web_s     = 1'b1;
    mem_csb_s     = {NBANK{1'b1}};
    mem_oeb_s     = {NBANK{1'b1}};
    mem_idata_s   = {DW{1'b0}};
    mem_sel_s     = {BANK_AW{1'b0}};
    spare_addr_s  = {SPARE_AW{1'b0}};
    spare_ce_s    = 1'b0;
    spare_csb_s   = 1'b1;
    spare_web_s   = 1'b1;
    spare_oeb_s   = 1'b1;
    spare_idata_s = {DW{1'b0}};
    if (BIST_EN) begin
      mem_addr_s  = BIST_MEM_ADDR;
      mem_ce_s    = BIST_MEM_CE;
      mem_web_s   = BIST_MEM_WEB;
      mem_csb_s   = BIST_MEM_CSB;
      mem_oeb_s   = BIST_MEM_OEB;
      mem_idata_s = BIST_MEM_IDATA;
      mem_sel_s   = BIST_MEM_ODATA_SELECT;
    end else if (!CSB) begin
      if (REPAIR_EN && hit_s) begin
        spare_addr_s  = hit_idx_s;
        spare_ce_s    = 1'b1;
        spare_csb_s   = 1'b0;
        spare_web_s   = WEB;
        spare_oeb_s   = OEB;
        spare_idata_s = IDATA;
      end else begin
        mem_addr_s  = word_s;
        mem_ce_s    = 1'b1;
        mem_web_s   = WEB;
        mem_csb_s   = ~(BANK_ONE << bank_s);
        mem_oeb_s   = {NBANK{OEB}} | ~(BANK_ONE << bank_s);
        mem_idata_s = IDATA;
        mem_sel_s   = bank_s;
      end
    end else begin
      mem_ce_s = 1'b0;
    end
  end

  // Memory-port output registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_addr_r    <= {WORD_AW{1'b0}};
      mem_ce_r      <= 1'b0;
      mem_web_r     <= 1'b1;
      mem_csb_r     <= {NBANK{1'b1}};
      mem_oeb_r     <= {NBANK{1'b1}};
      mem_idata_r   <= {DW{1'b0}};
      mem_sel_r     <= {BANK_AW{1'b0}};
      spare_addr_r  <= {SPARE_AW{1'b0}};
      spare_ce_r    <= 1'b0;
      spare_csb_r   <= 1'b1;
      spare_web_r   <= 1'b1;
      spare_oeb_r   <= 1'b1;
      spare_idata_r <= {DW{1'b0}};
    end else begin
      mem_addr_r    <= mem_addr_s;
      mem_ce_r      <= mem_ce_s;
      mem_web_r     <= mem_web_s;
      mem_csb_r     <= mem_csb_s;
      mem_oeb_r     <= mem_oeb_s;
      mem_idata_r   <= mem_idata_s;
      mem_sel_r     <= mem_sel_s;
      spare_addr_r  <= spare_addr_s;
      spare_ce_r    <= spare_ce_s;
      spare_csb_r   <= spare_csb_s;
      spare_web_r   <= spare_web_s;
      spare_oeb_r   <= spare_oeb_s;
      spare_idata_r <= spare_idata_s;
    end
  end

  // Two-stage read tracker: stage 1 while the SRAM samples, stage 2 while data is out
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      p1_vld_r <= 1'b0;
      p1_hit_r <= 1'b0;
      p2_vld_r <= 1'b0;
      p2_hit_r <= 1'b0;
    end else begin
      p1_vld_r <= rd_req_s;
      p1_hit_r <= rd_req_s && REPAIR_EN && hit_s;
      p2_vld_r <= p1_vld_r;
      p2_hit_r <= p1_hit_r;
    end
  end

  assign MEM_ADDR         = mem_addr_r;
  assign MEM_CE           = mem_ce_r;
  assign MEM_WEB          = mem_web_r;
  assign MEM_CSB          = mem_csb_r;
  assign MEM_OEB          = mem_oeb_r;
  assign MEM_IDATA        = mem_idata_r;
  assign MEM_ODATA_SELECT = mem_sel_r;
  assign SPARE_ADDR       = spare_addr_r;
  assign SPARE_CE         = spare_ce_r;
  assign SPARE_CSB        = spare_csb_r;
  assign SPARE_WEB        = spare_web_r;
  assign SPARE_OEB        = spare_oeb_r;
  assign SPARE_IDATA      = spare_idata_r;
  assign RVALID           = p2_vld_r;
  assign ODATA            = p2_vld_r ? (p2_hit_r ? SPARE_ODATA : MEM_ODATA) : {DW{1'b0}};
  assign REPAIR_CNT       = repair_cnt_r;
  assign REPAIR_FULL      = repair_full_r;
  assign REPAIR_OVF       = repair_ovf_r;

endmodule

// File: tb/tb_memctrl_remap.sv
// Bench for memctrl_remap: SRAM models on both ports, a queue-based reference
// model compared every cycle, and directed literal checks of the key scenarios.
module tb_memctrl_remap;
  localparam int BANK_AW = 6, WORD_AW = 10, DW = 8, SPARE_N = 16;
  localparam int NBANK = 64, SPARE_AW = 4, AW = 16;

  logic CLK = 1'b0, RSTN = 1'b0;
  logic BIST_EN, REPAIR_EN, REPAIR_CLR, CSB, WEB, OEB, FAIL_VALID;
  logic [AW-1:0] ADDR, FAIL_ADDR;
  logic [DW-1:0] IDATA, BIST_MEM_IDATA, MEM_ODATA = 8'h00, SPARE_ODATA = 8'h00;
  logic [WORD_AW-1:0] BIST_MEM_ADDR;
  logic BIST_MEM_CE, BIST_MEM_WEB;
  logic [NBANK-1:0] BIST_MEM_CSB, BIST_MEM_OEB;
  logic [BANK_AW-1:0] BIST_MEM_ODATA_SELECT;
  logic [WORD_AW-1:0] MEM_ADDR;
  logic MEM_CE, MEM_WEB, SPARE_CE, SPARE_CSB, SPARE_WEB, SPARE_OEB, RVALID, REPAIR_FULL, REPAIR_OVF;
  logic [NBANK-1:0] MEM_CSB, MEM_OEB;
  logic [DW-1:0] MEM_IDATA, SPARE_IDATA, ODATA;
  logic [BANK_AW-1:0] MEM_ODATA_SELECT;
  logic [SPARE_AW-1:0] SPARE_ADDR;
  logic [SPARE_AW:0] REPAIR_CNT;

  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  memctrl_remap #(.BANK_AW(BANK_AW), .WORD_AW(WORD_AW), .DW(DW), .SPARE_N(SPARE_N)) dut (
    .CLK(CLK), .RSTN(RSTN), .BIST_EN(BIST_EN), .REPAIR_EN(REPAIR_EN), .REPAIR_CLR(REPAIR_CLR),
    .CSB(CSB), .WEB(WEB), .OEB(OEB), .ADDR(ADDR), .IDATA(IDATA),
    .BIST_MEM_ADDR(BIST_MEM_ADDR), .BIST_MEM_CE(BIST_MEM_CE), .BIST_MEM_WEB(BIST_MEM_WEB),
    .BIST_MEM_CSB(BIST_MEM_CSB), .BIST_MEM_OEB(BIST_MEM_OEB), .BIST_MEM_IDATA(BIST_MEM_IDATA),
    .BIST_MEM_ODATA_SELECT(BIST_MEM_ODATA_SELECT), .FAIL_VALID(FAIL_VALID), .FAIL_ADDR(FAIL_ADDR),
    .MEM_ODATA(MEM_ODATA), .SPARE_ODATA(SPARE_ODATA), .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE),
    .MEM_WEB(MEM_WEB), .MEM_CSB(MEM_CSB), .MEM_OEB(MEM_OEB), .MEM_IDATA(MEM_IDATA),
    .MEM_ODATA_SELECT(MEM_ODATA_SELECT), .SPARE_ADDR(SPARE_ADDR), .SPARE_CE(SPARE_CE),
    .SPARE_CSB(SPARE_CSB), .SPARE_WEB(SPARE_WEB), .SPARE_OEB(SPARE_OEB), .SPARE_IDATA(SPARE_IDATA),
    .ODATA(ODATA), .RVALID(RVALID), .REPAIR_CNT(REPAIR_CNT), .REPAIR_FULL(REPAIR_FULL),
    .REPAIR_OVF(REPAIR_OVF)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM environment: synchronous write, registered read data
  bit [DW-1:0] env_main [65536];
  bit [DW-1:0] env_spare [SPARE_N];
  always @(posedge CLK) begin
    for (int b = 0; b < NBANK; b++)
      if (MEM_CE && !MEM_CSB[b] && !MEM_WEB) env_main[b*1024 + int'(MEM_ADDR)] = MEM_IDATA;
    if (MEM_CE && MEM_WEB) MEM_ODATA <= env_main[{MEM_ODATA_SELECT, MEM_ADDR}];
    if (SPARE_CE && !SPARE_CSB && !SPARE_WEB) env_spare[SPARE_ADDR] = SPARE_IDATA;
    if (SPARE_CE && !SPARE_CSB && SPARE_WEB) SPARE_ODATA <= env_spare[SPARE_ADDR];
  end

  // Reference model: table as an ordered list of addresses, reads as timed queue
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  bit [DW-1:0] m_main [65536];
  bit [DW-1:0] m_spare [SPARE_N];
  logic [AW-1:0] m_tbl [$];
  rd_t m_rdq [$];
  bit m_ovf = 1'b0;
  int cyc_n = 0;
  logic [63:0] e_mem_csb, e_mem_oeb;
  logic [9:0] e_mem_addr;
  logic [7:0] e_mem_idata, e_sp_idata, e_odata;
  logic [5:0] e_mem_sel;
  logic [3:0] e_sp_addr;
  logic e_mem_ce, e_mem_web, e_sp_ce, e_sp_csb, e_sp_web, e_sp_oeb, e_rvalid, e_full;
  int e_cnt;

  function automatic int lookup(input logic [AW-1:0] a);
    for (int i = 0; i < m_tbl.size(); i++) if (m_tbl[i] == a) return i;
    return -1;
  endfunction

  always @(posedge CLK) begin
    int idx, bank;
    rd_t r;
    cyc_n++;
    e_mem_csb = '1; e_mem_oeb = '1; e_mem_web = 1'b1; e_mem_ce = 1'b0;
    e_mem_addr = '0; e_mem_idata = '0; e_mem_sel = '0;
    e_sp_addr = '0; e_sp_ce = 1'b0; e_sp_csb = 1'b1; e_sp_web = 1'b1; e_sp_oeb = 1'b1; e_sp_idata = '0;
    e_rvalid = 1'b0; e_odata = '0;
    if (!RSTN) begin
      m_tbl.delete(); m_rdq.delete(); m_ovf = 1'b0;
    end else begin
      if (m_rdq.size() > 0 && m_rdq[0].due == cyc_n) begin
        e_rvalid = 1'b1; e_odata = m_rdq[0].data; void'(m_rdq.pop_front());
      end
      idx = lookup(ADDR);
      bank = int'(ADDR) / 1024;
      if (BIST_EN) begin
        e_mem_csb = BIST_MEM_CSB; e_mem_oeb = BIST_MEM_OEB; e_mem_web = BIST_MEM_WEB;
        e_mem_ce = BIST_MEM_CE; e_mem_addr = BIST_MEM_ADDR; e_mem_idata = BIST_MEM_IDATA;
        e_mem_sel = BIST_MEM_ODATA_SELECT;
        for (int b = 0; b < NBANK; b++)
          if (BIST_MEM_CE && !BIST_MEM_CSB[b] && !BIST_MEM_WEB) m_main[b*1024 + int'(BIST_MEM_ADDR)] = BIST_MEM_IDATA;
      end else if (!CSB) begin
        if (REPAIR_EN && idx >= 0) begin
          e_sp_addr = 4'(idx); e_sp_ce = 1'b1; e_sp_csb = 1'b0; e_sp_web = WEB; e_sp_oeb = OEB; e_sp_idata = IDATA;
          if (!WEB) m_spare[idx] = IDATA;
        end else begin
          e_mem_csb = ~(64'd1 << bank);
          e_mem_oeb = OEB ? '1 : ~(64'd1 << bank);
          e_mem_web = WEB; e_mem_ce = 1'b1; e_mem_addr = ADDR % 1024; e_mem_idata = IDATA; e_mem_sel = 6'(bank);
          if (!WEB) m_main[ADDR] = IDATA;
        end
        if (WEB && !OEB) begin
          r.due = cyc_n + 1;
          r.data = (REPAIR_EN && idx >= 0) ? m_spare[idx] : m_main[ADDR];
          m_rdq.push_back(r);
        end
      end
      if (REPAIR_CLR) begin
        m_tbl.delete(); m_ovf = 1'b0;
      end else if (BIST_EN && FAIL_VALID && lookup(FAIL_ADDR) < 0) begin
        if (m_tbl.size() < SPARE_N) m_tbl.push_back(FAIL_ADDR);
        else m_ovf = 1'b1;
      end
    end
    e_cnt = m_tbl.size();
    e_full = (m_tbl.size() == SPARE_N);
  end

  // Every-cycle comparison on the falling edge; asserted reset forces reset values
  always @(negedge CLK) begin
    if (chk_en) begin
      check("MEM_CSB",   MEM_CSB,   RSTN ? e_mem_csb : 64'hFFFF_FFFF_FFFF_FFFF);
      check("MEM_OEB",   MEM_OEB,   RSTN ? e_mem_oeb : 64'hFFFF_FFFF_FFFF_FFFF);
      check("MEM_WEB",   64'(MEM_WEB),   64'(RSTN ? e_mem_web : 1'b1));
      check("MEM_CE",    64'(MEM_CE),    64'(RSTN ? e_mem_ce : 1'b0));
      check("MEM_ADDR",  64'(MEM_ADDR),  64'(RSTN ? e_mem_addr : 10'd0));
      check("MEM_IDATA", 64'(MEM_IDATA), 64'(RSTN ? e_mem_idata : 8'd0));
      check("MEM_SEL",   64'(MEM_ODATA_SELECT), 64'(RSTN ? e_mem_sel : 6'd0));
      check("SPARE_ADDR",  64'(SPARE_ADDR),  64'(RSTN ? e_sp_addr : 4'd0));
      check("SPARE_CE",    64'(SPARE_CE),    64'(RSTN ? e_sp_ce : 1'b0));
      check("SPARE_CSB",   64'(SPARE_CSB),   64'(RSTN ? e_sp_csb : 1'b1));
      check("SPARE_WEB",   64'(SPARE_WEB),   64'(RSTN ? e_sp_web : 1'b1));
      check("SPARE_OEB",   64'(SPARE_OEB),   64'(RSTN ? e_sp_oeb : 1'b1));
      check("SPARE_IDATA", 64'(SPARE_IDATA), 64'(RSTN ? e_sp_idata : 8'd0));
      check("RVALID",      64'(RVALID),      64'(RSTN ? e_rvalid : 1'b0));
      check("REPAIR_CNT",  64'(REPAIR_CNT),  RSTN ? 64'(e_cnt) : 64'd0);
      check("REPAIR_FULL", 64'(REPAIR_FULL), 64'(RSTN ? e_full : 1'b0));
      check("REPAIR_OVF",  64'(REPAIR_OVF),  64'(RSTN ? m_ovf : 1'b0));
      if (RSTN && e_rvalid) check("ODATA", 64'(ODATA), 64'(e_odata));
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic idle_in();
    CSB = 1'b1; WEB = 1'b1; OEB = 1'b1; ADDR = '0; IDATA = '0;
    FAIL_VALID = 1'b0; FAIL_ADDR = '0; REPAIR_CLR = 1'b0;
    BIST_MEM_ADDR = '0; BIST_MEM_CE = 1'b0; BIST_MEM_WEB = 1'b1;
    BIST_MEM_CSB = '1; BIST_MEM_OEB = '1; BIST_MEM_IDATA = '0; BIST_MEM_ODATA_SELECT = '0;
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    idle_in(); BIST_EN = 1'b0; REPAIR_EN = 1'b0;
    repeat (3) cyc();
    chk_en = 1'b1;
    RSTN = 1'b1;
    cyc();
    check("init_cnt", 64'(REPAIR_CNT), 64'd0);

    // functional miss: write then read bank 7 word 5
    CSB = 1'b0; WEB = 1'b0; OEB = 1'b1; ADDR = 16'h1C05; IDATA = 8'hA5; cyc();
    check("miss_wr_csb", MEM_CSB, 64'hFFFF_FFFF_FFFF_FF7F);
    check("miss_wr_addr", 64'(MEM_ADDR), 64'h005);
    check("miss_wr_web", 64'(MEM_WEB), 64'd0);
    WEB = 1'b1; OEB = 1'b0; cyc();
    check("miss_rd_oeb", MEM_OEB, 64'hFFFF_FFFF_FFFF_FF7F);
    check("miss_rd_sel", 64'(MEM_ODATA_SELECT), 64'd7);
    check("miss_rv_early", 64'(RVALID), 64'd0);
    idle_in(); cyc();
    check("miss_rvalid", 64'(RVALID), 64'd1);
    check("miss_odata", 64'(ODATA), 64'hA5);
    cyc();
    check("miss_rv_pulse", 64'(RVALID), 64'd0);

    // insert the same failure twice, then access through the spare
    BIST_EN = 1'b1; FAIL_VALID = 1'b1; FAIL_ADDR = 16'h1C05; cyc(); cyc();
    check("ins_cnt", 64'(REPAIR_CNT), 64'd1);
    idle_in(); BIST_EN = 1'b0; REPAIR_EN = 1'b1;
    CSB = 1'b0; WEB = 1'b0; ADDR = 16'h1C05; IDATA = 8'h5A; cyc();
    check("hit_sp_csb", 64'(SPARE_CSB), 64'd0);
    check("hit_sp_addr", 64'(SPARE_ADDR), 64'd0);
    check("hit_mem_ce", 64'(MEM_CE), 64'd0);
    check("hit_mem_csb", MEM_CSB, 64'hFFFF_FFFF_FFFF_FFFF);
    WEB = 1'b1; OEB = 1'b0; cyc();
    idle_in(); cyc();
    check("hit_odata", 64'(ODATA), 64'h5A);
    REPAIR_EN = 1'b0; CSB = 1'b0; WEB = 1'b1; OEB = 1'b0; ADDR = 16'h1C05; cyc();
    check("norep_csb", MEM_CSB, 64'hFFFF_FFFF_FFFF_FF7F);
    check("norep_sp_csb", 64'(SPARE_CSB), 64'd1);
    idle_in(); cyc();
    check("norep_odata", 64'(ODATA), 64'hA5);

    // overflow: 17 distinct failures into an emptied table
    BIST_EN = 1'b1; REPAIR_CLR = 1'b1; cyc(); REPAIR_CLR = 1'b0;
    check("clr_cnt", 64'(REPAIR_CNT), 64'd0);
    for (int i = 0; i < 17; i++) begin
      FAIL_VALID = 1'b1; FAIL_ADDR = 16'h0100 + 16'(i); cyc();
      if (i == 14) check("ovf_full14", 64'(REPAIR_FULL), 64'd0);
      if (i == 15) begin
        check("ovf_full16", 64'(REPAIR_FULL), 64'd1);
        check("ovf_ovf16", 64'(REPAIR_OVF), 64'd0);
      end
    end
    FAIL_VALID = 1'b0;
    check("ovf_cnt", 64'(REPAIR_CNT), 64'd16);
    check("ovf_ovf", 64'(REPAIR_OVF), 64'd1);

    // clear beats a same-cycle insert
    REPAIR_CLR = 1'b1; FAIL_VALID = 1'b1; FAIL_ADDR = 16'h2222; cyc();
    REPAIR_CLR = 1'b0; FAIL_VALID = 1'b0;
    check("clrp_cnt", 64'(REPAIR_CNT), 64'd0);
    check("clrp_ovf", 64'(REPAIR_OVF), 64'd0);
    check("clrp_full", 64'(REPAIR_FULL), 64'd0);
    BIST_EN = 1'b0; REPAIR_EN = 1'b1; CSB = 1'b0; WEB = 1'b1; OEB = 1'b0; ADDR = 16'h0100; cyc();
    check("clrp_mem_ce", 64'(MEM_CE), 64'd1);
    check("clrp_mem_csb", MEM_CSB, 64'hFFFF_FFFF_FFFF_FFFE);
    check("clrp_sp_csb", 64'(SPARE_CSB), 64'd1);
    idle_in(); cyc(); cyc();

    // BIST passthrough while a functional read is presented
    BIST_EN = 1'b1; BIST_MEM_CSB = ~(64'd1 << 3); BIST_MEM_CE = 1'b1; BIST_MEM_WEB = 1'b1;
    BIST_MEM_ADDR = 10'h003; BIST_MEM_ODATA_SELECT = 6'd3; CSB = 1'b0; OEB = 1'b0; cyc();
    check("bist_csb", MEM_CSB, 64'hFFFF_FFFF_FFFF_FFF7);
    check("bist_ce", 64'(MEM_CE), 64'd1);
    check("bist_sp_csb", 64'(SPARE_CSB), 64'd1);
    cyc(); cyc();
    check("bist_rv", 64'(RVALID), 64'd0);
    idle_in(); BIST_EN = 1'b0; cyc();

    // randomized traffic against the model
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
    pool[0] = 16'h1C05;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) BIST_EN = ~BIST_EN;
      REPAIR_EN = ($urandom_range(0, 3) != 0);
      REPAIR_CLR = ($urandom_range(0, 199) == 0);
      CSB = ($urandom_range(0, 9) < 3);
      WEB = $urandom_range(0, 1) == 1; OEB = $urandom_range(0, 3) == 0;
      ADDR = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : 16'($urandom);
      IDATA = 8'($urandom);
      FAIL_VALID = ($urandom_range(0, 3) == 0);
      FAIL_ADDR = ($urandom_range(0, 7) != 0) ? pool[$urandom_range(0, 7)] : 16'($urandom);
      BIST_MEM_CE = $urandom_range(0, 1) == 1; BIST_MEM_WEB = $urandom_range(0, 1) == 1;
      BIST_MEM_CSB = ($urandom_range(0, 1) == 1) ? ~(64'd1 << $urandom_range(0, 63)) : '1;
      BIST_MEM_OEB = {$urandom, $urandom};
      BIST_MEM_ADDR = 10'($urandom); BIST_MEM_IDATA = 8'($urandom);
      BIST_MEM_ODATA_SELECT = 6'($urandom);
      cyc();
    end

    // reset asserted with a read in flight
    idle_in(); BIST_EN = 1'b0; REPAIR_EN = 1'b0; cyc(); cyc(); cyc();
    CSB = 1'b0; WEB = 1'b1; OEB = 1'b0; ADDR = 16'h1C05; cyc();
    idle_in(); RSTN = 1'b0; #1;
    check("rst_rv", 64'(RVALID), 64'd0);
    check("rst_csb", MEM_CSB, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_ce", 64'(MEM_CE), 64'd0);
    check("rst_sp_csb", 64'(SPARE_CSB), 64'd1);
    cyc();
    check("rst_rv2", 64'(RVALID), 64'd0);
    RSTN = 1'b1; cyc();
    check("rst_rv3", 64'(RVALID), 64'd0);
    check("rst_cnt", 64'(REPAIR_CNT), 64'd0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memctrl_remap.md
# memctrl_remap

Parametrised memory-controller front end with built-in address repair. It arbitrates the banked main SRAM between BIST and functional access, and captures BIST-reported failing addresses into a repair table. In functional mode it redirects hits on that table to a spare SRAM and returns read data through a pipelined output mux. It sits between the system bus and the banked main and spare SRAM arrays.

## Interface
Parameters:
- BANK_AW, 6: bank index bits; NBANK = 2**BANK_AW banks.
- WORD_AW, 10: word address bits per bank.
- DW, 8: data width.
- SPARE_N, 16: repair-table entries, equal to spare SRAM words; SPARE_AW = $clog2(SPARE_N).
- AW is derived: AW = BANK_AW+WORD_AW.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock, all state on posedge.
- RSTN  in  1  asynchronous active-low reset.
- BIST_EN  in  1  1 = BIST owns the main array.
- REPAIR_EN  in  1  1 = functional lookups use the repair table.
- REPAIR_CLR  in  1  synchronous clear of the repair table.
- CSB, WEB, OEB  in  1 each  functional chip select, write enable, output enable; all active-low.
- ADDR  in  AW  functional address; [AW-1:WORD_AW] is the bank, [WORD_AW-1:0] is the word.
- IDATA  in  DW  functional write data.
- BIST_MEM_ADDR  in  WORD_AW  BIST word address.
- BIST_MEM_CE, BIST_MEM_WEB  in  1  BIST controls.
- BIST_MEM_CSB, BIST_MEM_OEB  in  NBANK  BIST per-bank selects, active-low.
- BIST_MEM_IDATA  in  DW  BIST write data.
- BIST_MEM_ODATA_SELECT  in  BANK_AW  BIST read bank.
- FAIL_VALID  in  1  BIST failure strobe.
- FAIL_ADDR  in  AW  failing full address.
- MEM_ODATA, SPARE_ODATA  in  DW  SRAM read data.
- MEM_ADDR  out  WORD_AW  main word address.
- MEM_CE, MEM_WEB  out  1  main array controls.
- MEM_CSB, MEM_OEB  out  NBANK  main per-bank selects, active-low.
- MEM_IDATA  out  DW  main write data.
- MEM_ODATA_SELECT  out  BANK_AW  main read bank.
- SPARE_ADDR  out  SPARE_AW  spare word address.
- SPARE_CE, SPARE_CSB, SPARE_WEB, SPARE_OEB  out  1  spare controls (CSB/WEB/OEB active-low).
- SPARE_IDATA  out  DW  spare write data.
- ODATA  out  DW  functional read data.
- RVALID  out  1  ODATA valid strobe.
- REPAIR_CNT  out  SPARE_AW+1  number of valid table entries.
- REPAIR_FULL  out  1  table full.
- REPAIR_OVF  out  1  sticky: a failure was dropped because the table was full.

## Operation
- Repair table: SPARE_N entries of {valid, AW-bit address}. Entry i maps to spare word i. Entries are filled in order 0,1,2…; REPAIR_CNT is the next free index.
- Insert: applies when BIST_EN=1 and FAIL_VALID=1.
  - FAIL_ADDR matches a valid entry: ignore.
  - Table not full: write the entry at REPAIR_CNT and increment REPAIR_CNT.
  - Table full: set REPAIR_OVF; table unchanged.
- FAIL_VALID is ignored when BIST_EN=0.
- REPAIR_CLR: invalidate all entries, REPAIR_CNT=0, REPAIR_OVF=0. Clear has priority over a same-cycle insert.
- Table contents persist across BIST_EN transitions.
- BIST mode (BIST_EN=1): all BIST_MEM_* inputs are registered to the matching MEM_* outputs. The spare port is idle. ODATA/RVALID are not generated (RVALID=0).
- Functional mode (BIST_EN=0): a request is valid when CSB=0. Lookup is a combinational compare of ADDR against all valid entries.
  - Hit (REPAIR_EN=1): SPARE_CSB=0, SPARE_CE=1, SPARE_ADDR=hit index, SPARE_WEB=WEB, SPARE_OEB=OEB, SPARE_IDATA=IDATA. Main is idle: MEM_CSB/MEM_OEB all ones, MEM_WEB=1, MEM_CE=0.
  - Miss, or REPAIR_EN=0: MEM_CSB = ~(1<<bank) when CSB=0, otherwise all ones. MEM_OEB = {NBANK{OEB}} | ~(1<<bank). MEM_ADDR = word, MEM_WEB=WEB, MEM_IDATA=IDATA, MEM_CE=1, MEM_ODATA_SELECT=bank. Spare is idle.
- Idle values: CE=0, CSB/OEB/WEB=1, address and data hold 0.
- Read return: a request with CSB=0, WEB=1, OEB=0 enqueues {read, hit, bank} into a 2-stage pipe. ODATA = SPARE_ODATA if hit, else MEM_ODATA. MEM_ODATA is already bank-selected externally via MEM_ODATA_SELECT.

## Timing
- Reset values: all CSB/OEB/WEB outputs = all ones; CE outputs = 0; addresses, data, ODATA_SELECT = 0; RVALID=0; REPAIR_CNT=0; REPAIR_FULL=0; REPAIR_OVF=0; table invalid.
- Request sampled at edge E0 → memory ports driven after E0 (1-cycle latency).
- SRAM samples at E1; RVALID=1 for one cycle after E1. ODATA is valid while RVALID=1.
- Back-to-back reads every cycle give RVALID every cycle, in order.
- An insert at edge E becomes visible to lookups after E. REPAIR_FULL = (REPAIR_CNT==SPARE_N), registered.
- BIST_EN change: it takes effect on the request sampled at the same edge. In-flight reads still complete.
- RSTN asserted mid-read: the pipe is flushed and no RVALID follows.

## Test plan
- Reset: assert RSTN=0 mid-traffic → every output at its reset value; after release, REPAIR_CNT=0.
- Functional miss: write ADDR=0x1C05, IDATA=0xA5, then read → MEM_CSB bit 7 low only, MEM_ADDR=0x005, ODATA=0xA5, RVALID 2 cycles after the read is sampled.
- Insert and repair: BIST_EN=1, FAIL_VALID with FAIL_ADDR=0x1C05 twice → REPAIR_CNT=1. Then functional write/read 0x1C05 → SPARE_ADDR=0, main idle, ODATA from spare. With REPAIR_EN=0 the same access goes to main.
- Overflow: with SPARE_N=16, inject 17 distinct failures → REPAIR_FULL=1 after the 16th, REPAIR_OVF=1 after the 17th, REPAIR_CNT=16.
- Clear priority: REPAIR_CLR and FAIL_VALID in the same cycle → REPAIR_CNT=0, REPAIR_OVF=0; a subsequent access to the previously repaired address goes to main.
- BIST passthrough: BIST_EN=1 with BIST_MEM_CSB=~(1<<3) → MEM_CSB matches one cycle later; spare idle; RVALID stays 0.
